sprite_bitmap_writer: RTL

- Writable, double-buffered 32x32 sprite bitmap. It is the writer end of the bitmap draw interface.
- A loader streams 8-bit RGB pixels in raster order into the back bank through a valid/ready handshake. The bank swap happens on the next startOfFrame, so images never tear.
- The front bank is read with the standard draw interface (offsetX/offsetY/InsideRectangle in, drawingRequest/RGBout out). The block drops into the objects mux in place of a fixed-ROM bitmap.

---
 rtl/sprite_bitmap_writer_if.sv | 41 ++++
 rtl/sprite_bitmap_writer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_bitmap_writer_if.sv
// ---------------------------------------------------------------------------
// sprite_bitmap_writer_if
//   Loader-side bus of the writable sprite bitmap.
//
//   Handshake: a pixel beat transfers on a rising clk edge where wr_valid and
//   wr_ready are both 1. The loader holds wr_data/wr_last stable while
//   wr_valid is high and wr_ready is low. wr_ready may depend combinationally
//   on clear, but never on wr_valid. wr_last only has meaning when wr_valid is 1.
//   clear is a one-cycle request that is not part of the handshake and always
//   wins over a coincident beat.
//
//   Signals:
//     wr_valid  loader -> writer  pixel beat valid
//     wr_ready  writer -> loader  writer accepts the beat this cycle
//     wr_data   loader -> writer  RGB332 pixel
//     wr_last   loader -> writer  final pixel of the image
//     clear     loader -> writer  fill the back bank with transparent
// ---------------------------------------------------------------------------
interface sprite_bitmap_writer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       wr_last;
  logic       clear;

  modport master (
    output wr_valid,
    output wr_data,
    output wr_last,
    output clear,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    input  wr_last,
    input  clear,
    output wr_ready
  );
endinterface

// File: rtl/sprite_bitmap_writer.sv
// ---------------------------------------------------------------------------
// sprite_bitmap_writer
//   Double-buffered WIDTH x HEIGHT sprite bitmap. A loader fills the back bank
//   in raster order; the banks swap on the next startOfFrame once the back
//   image is complete, so the displayed image never tears. The front bank is
//   read through the standard draw interface with one cycle of latency.
//
//   Ports:
//     clk             system clock
//     reset           synchronous, active-high reset
//     wr_if           loader bus (slave side): wr_valid/wr_ready/wr_data/
//                     wr_last/clear
//     startOfFrame    one-cycle frame-start pulse, the bank swap point
//     offsetX/Y       pixel offset from the sprite top-left corner
//     InsideRectangle pixel lies within the sprite bracket
//     drawingRequest  registered pixel is not transparent
//     RGBout          registered pixel colour
//     busy            writer FSM is not idle
//     load_error      sticky: an image filled the bank without wr_last
//     state_dbg       writer FSM state (0 idle, 1 load, 2 clear, 3 pending)
// ---------------------------------------------------------------------------
module sprite_bitmap_writer #(
  parameter int          WIDTH                = 32,
  parameter int          HEIGHT               = 32,
  parameter logic [7:0]  TRANSPARENT_ENCODING = 8'hFF
) (
  input  logic                      clk,
  input  logic                      reset,
  sprite_bitmap_writer_if.slave     wr_if,
  input  logic                      startOfFrame,
  input  logic [10:0]               offsetX,
  input  logic [10:0]               offsetY,
  input  logic                      InsideRectangle,
  output logic                      drawingRequest,
  output logic [7:0]                RGBout,
  output logic                      busy,
  output logic                      load_error,
  output logic [1:0]                state_dbg
);

  localparam int COL_W  = $clog2(WIDTH);
  localparam int ROW_W  = $clog2(HEIGHT);
  localparam int ADDR_W = COL_W + ROW_W;
  localparam int DEPTH  = WIDTH * HEIGHT;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [10:0]       WIDTH_L   = 11'(WIDTH);
  localparam logic [10:0]       HEIGHT_L  = 11'(HEIGHT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_CLEAR   = 2'd2,
    S_PENDING = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   wr_addr, wr_addr_n;
  logic                front_sel, front_valid;
  logic                swap;
  logic                mem_we;
  logic [7:0]          mem_wdata;
  logic                set_error;
  logic                wr_fire;
  logic                at_last;

  // Both banks in one array; the top address bit is the bank select, the
  // rest is {row, col}.
  logic [7:0] mem [0:2*DEPTH-1];

  assign wr_if.wr_ready = ((state == S_IDLE) || (state == S_LOAD)) && !wr_if.clear;
  assign wr_fire        = wr_if.wr_valid && wr_if.wr_ready;
  assign at_last        = (wr_addr == LAST_ADDR);

  // -------------------------------------------------------------------------
  // Writer FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      wr_addr     <= '0;
      front_sel   <= 1'b0;
      front_valid <= 1'b0;
      load_error  <= 1'b0;
    end else begin
      state   <= state_n;
      wr_addr <= wr_addr_n;
      if (swap) begin
        front_sel   <= ~front_sel;
        front_valid <= 1'b1;
      end
      if (set_error) begin
        load_error <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Writer FSM: next state, back-bank write strobe
  // -------------------------------------------------------------------------
  always_comb begin
    state_n   = state;
    wr_addr_n = wr_addr;
    mem_we    = 1'b0;
    mem_wdata = wr_if.wr_data;
    set_error = 1'b0;
    swap      = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (wr_if.clear) begin
          wr_addr_n = '0;
          state_n   = S_CLEAR;
        end else if (wr_fire) begin
          // wr_addr is always 0 in IDLE, so this is pixel 0.
          mem_we    = 1'b1;
          wr_addr_n = ADDR_W'(1);
          state_n   = wr_if.wr_last ? S_CLEAR : S_LOAD;
        end
      end

      S_LOAD: begin
        if (wr_if.clear) begin
          wr_addr_n = '0;
          state_n   = S_CLEAR;
        end else if (wr_fire) begin
          mem_we = 1'b1;
          if (at_last) begin
            // The image exactly fills the bank; it must have ended here.
            set_error = !wr_if.wr_last;
            state_n   = S_PENDING;
          end else begin
            wr_addr_n = wr_addr + ADDR_W'(1);
            // Short image: pad the remainder with transparent pixels.
            if (wr_if.wr_last) begin
              state_n = S_CLEAR;
            end
          end
        end
      end

      S_CLEAR: begin
        if (wr_if.clear) begin
          wr_addr_n = '0;
        end else begin
          mem_we    = 1'b1;
          mem_wdata = TRANSPARENT_ENCODING;
          if (at_last) begin
            state_n = S_PENDING;
          end else begin
            wr_addr_n = wr_addr + ADDR_W'(1);
          end
        end
      end

      S_PENDING: begin
        if (wr_if.clear) begin
          wr_addr_n = '0;
          state_n   = S_CLEAR;
        end else if (startOfFrame) begin
          swap      = 1'b1;
          wr_addr_n = '0;
          state_n   = S_IDLE;
        end
      end

      default: begin
        state_n   = S_IDLE;
        wr_addr_n = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Back-bank write port
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[{~front_sel, wr_addr}] <= mem_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Front-bank read port. front_sel is sampled before a swap takes effect, so
  // the pixel registered on the swap edge still comes from the old bank.
  // -------------------------------------------------------------------------
  logic rd_hit;
  assign rd_hit = InsideRectangle && front_valid &&
                  (offsetX < WIDTH_L) && (offsetY < HEIGHT_L);

  always_ff @(posedge clk) begin
    if (reset) begin
      RGBout <= TRANSPARENT_ENCODING;
    end else if (rd_hit) begin
      RGBout <= mem[{front_sel, offsetY[ROW_W-1:0], offsetX[COL_W-1:0]}];
    end else begin
      RGBout <= TRANSPARENT_ENCODING;
    end
  end

  assign drawingRequest = (RGBout != TRANSPARENT_ENCODING);
  assign busy           = (state != S_IDLE);
  assign state_dbg      = state;

endmodule
